flippy_guess_entry: RTL and testbench

//  Producer side of the column guess interface: turns the DE0 slide switches plus the submit pushbutton

---
 rtl/flippy_guess_entry_if.sv | 26 ++
 rtl/flippy_guess_entry.sv | 136 +++++++++++++
 tb/tb_flippy_guess_entry.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/flippy_guess_entry_if.sv
// Guess bus between the switch/button entry block and the falling columns.
interface flippy_guess_entry_if;
  localparam int unsigned GUESS_W = 8;

  logic [GUESS_W-1:0] switches;
  logic               submit_button;
  logic [GUESS_W-1:0] user_input;
  logic               guess_valid;
  logic               button_pressed;

  modport master (
    input  switches,
    input  submit_button,
    output user_input,
    output guess_valid,
    output button_pressed
  );

  modport slave (
    output switches,
    output submit_button,
    input  user_input,
    input  guess_valid,
    input  button_pressed
  );
endinterface

// File: rtl/flippy_guess_entry.sv
// Turns raw slide switches plus the submit pushbutton into a time-boxed guess on user_input.
// Button and switches are synchronised, the button debounced, and each clean press presents one guess.
module flippy_guess_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 4,
  parameter logic [7:0]  IDLE_VALUE      = 8'd0
) (
  input logic                   clock,
  input logic                   reset_signal_n,
  flippy_guess_entry_if.master  bus
);

  localparam int unsigned GUESS_W = 8;
  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESENT      = 2'd1,
    S_WAIT_RELEASE = 2'd2
  } state_e;

  logic               btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic [GUESS_W-1:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [CNT_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic               pressed_q, pressed_d;
  logic               pressed_prev_q, pressed_prev_d;
  logic               press_edge_q, press_edge_d;
  logic               btn_level;

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [GUESS_W-1:0] user_input_q, user_input_d;
  logic               guess_valid_q, guess_valid_d;

  // Synchroniser and debounce registers; button sync resets to the released (high) level.
  always_ff @(posedge clock or negedge reset_signal_n) begin
    if (!reset_signal_n) begin
      btn_s1_q       <= 1'b1;
      btn_s2_q       <= 1'b1;
      sw_s1_q        <= '0;
      sw_s2_q        <= '0;
      deb_cnt_q      <= '0;
      pressed_q      <= 1'b0;
      pressed_prev_q <= 1'b0;
      press_edge_q   <= 1'b0;
    end else begin
      btn_s1_q       <= btn_s1_d;
      btn_s2_q       <= btn_s2_d;
      sw_s1_q        <= sw_s1_d;
      sw_s2_q        <= sw_s2_d;
      deb_cnt_q      <= deb_cnt_d;
      pressed_q      <= pressed_d;
      pressed_prev_q <= pressed_prev_d;
      press_edge_q   <= press_edge_d;
    end
  end

  // Debounced level flips only after the synced level disagrees for DEBOUNCE_CYCLES cycles in a row.
  always_comb begin
    btn_s1_d       = bus.submit_button;
    btn_s2_d       = btn_s1_q;
    sw_s1_d        = bus.switches;
    sw_s2_d        = sw_s1_q;
    btn_level      = ~btn_s2_q;
    pressed_d      = pressed_q;
    deb_cnt_d      = '0;
    pressed_prev_d = pressed_q;
    press_edge_d   = pressed_q & ~pressed_prev_q;
    if (btn_level != pressed_q) begin
      if (deb_cnt_q == CNT_MAX) begin
        pressed_d = ~pressed_q;
      end else begin
        deb_cnt_d = deb_cnt_q + CNT_W'(1);
      end
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clock or negedge reset_signal_n) begin
    if (!reset_signal_n) begin
      state_q       <= S_IDLE;
      hold_q        <= '0;
      user_input_q  <= IDLE_VALUE;
      guess_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      user_input_q  <= user_input_d;
      guess_valid_q <= guess_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:         if (press_edge_q) state_d = S_PRESENT;
      S_PRESENT:      if (hold_q == '0) state_d = S_WAIT_RELEASE;
      S_WAIT_RELEASE: if (!pressed_q)   state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Guess is captured from the synced switches only on the press edge and then frozen for the window.
  always_comb begin
    user_input_d  = user_input_q;
    guess_valid_d = 1'b0;
    hold_d        = hold_q;
    unique case (state_q)
      S_IDLE: begin
        user_input_d = IDLE_VALUE;
        if (press_edge_q) begin
          user_input_d  = sw_s2_q;
          guess_valid_d = 1'b1;
          hold_d        = HOLD_LOAD;
        end
      end
      S_PRESENT: begin
        if (hold_q == '0) begin
          user_input_d = IDLE_VALUE;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      S_WAIT_RELEASE: user_input_d = IDLE_VALUE;
      default:        user_input_d = IDLE_VALUE;
    endcase
  end

  assign bus.user_input     = user_input_q;
  assign bus.guess_valid    = guess_valid_q;
  assign bus.button_pressed = pressed_q;

endmodule

// File: tb/tb_flippy_guess_entry.sv
// Directed bench for flippy_guess_entry with DEBOUNCE_CYCLES=4, HOLD_CYCLES=3, IDLE_VALUE=0.
module tb_flippy_guess_entry;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   pulses, hits, bp_hi, nonzero;
  bit   found;

  flippy_guess_entry_if bus ();

  flippy_guess_entry #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (3),
    .IDLE_VALUE      (8'h00)
  ) dut (
    .clock          (clk),
    .reset_signal_n (rst_n),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs n cycles with inputs frozen, counting pulses, cycles showing val, and pressed cycles.
  task automatic run_obs(input int n, input logic [7:0] val,
                         output int p, output int h, output int b);
    p = 0; h = 0; b = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.guess_valid === 1'b1) p++;
      if (bus.user_input === val) h++;
      if (bus.button_pressed === 1'b1) b++;
    end
  endtask

  // Bounded wait for the guess_valid pulse.
  task automatic wait_pulse(output bit f);
    f = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.guess_valid === 1'b1) begin
        f = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.switches      = 8'hA5;
    bus.submit_button = 1'b0;

    // Reset with button held
    repeat (3) tick();
    chk8("rst_user_input", bus.user_input, 8'h00);
    chk1("rst_guess_valid", bus.guess_valid, 1'b0);
    chk1("rst_button_pressed", bus.button_pressed, 1'b0);

    // Button held through reset release: one guess of A5
    rst_n = 1'b1;
    run_obs(20, 8'hA5, pulses, hits, bp_hi);
    chki("held_rst_pulses", pulses, 1);
    chki("held_rst_hits", hits, 3);
    bus.submit_button = 1'b1;
    run_obs(15, 8'hA5, pulses, hits, bp_hi);
    chki("held_rst_rel_pulses", pulses, 0);
    chk1("held_rst_rel_bp", bus.button_pressed, 1'b0);

    // Clean press, cycle-exact latency and window
    bus.switches = 8'h41;
    repeat (2) tick();
    bus.submit_button = 1'b0;
    repeat (5) tick();
    chk1("press_bp_before", bus.button_pressed, 1'b0);
    tick();
    chk1("press_bp_after", bus.button_pressed, 1'b1);
    chk8("press_ui_e6", bus.user_input, 8'h00);
    tick();
    chk8("press_ui_e7", bus.user_input, 8'h00);
    chk1("press_gv_e7", bus.guess_valid, 1'b0);
    tick();
    chk8("press_ui_e8", bus.user_input, 8'h41);
    chk1("press_gv_e8", bus.guess_valid, 1'b1);
    tick();
    chk8("press_ui_e9", bus.user_input, 8'h41);
    chk1("press_gv_e9", bus.guess_valid, 1'b0);
    tick();
    chk8("press_ui_e10", bus.user_input, 8'h41);
    tick();
    chk8("press_ui_e11", bus.user_input, 8'h00);
    chk1("press_gv_e11", bus.guess_valid, 1'b0);
    run_obs(9, 8'h41, pulses, hits, bp_hi);
    chki("press_held_pulses", pulses, 0);
    chki("press_held_hits", hits, 0);
    bus.submit_button = 1'b1;
    run_obs(15, 8'h41, pulses, hits, bp_hi);
    chki("press_rel_pulses", pulses, 0);
    chk1("press_rel_bp", bus.button_pressed, 1'b0);

    // Bounce: low 3, high 1, low 3
    pulses = 0; bp_hi = 0; nonzero = 0;
    for (int i = 0; i < 16; i++) begin
      bus.submit_button = !((i < 3) || (i >= 4 && i < 7));
      tick();
      if (bus.guess_valid === 1'b1) pulses++;
      if (bus.button_pressed === 1'b1) bp_hi++;
      if (bus.user_input !== 8'h00) nonzero++;
    end
    chki("bounce_pulses", pulses, 0);
    chki("bounce_bp", bp_hi, 0);
    chki("bounce_ui", nonzero, 0);

    // Switches change during the window
    bus.switches = 8'h41;
    repeat (2) tick();
    bus.submit_button = 1'b0;
    wait_pulse(found);
    chk1("swchg_found", found, 1'b1);
    chk8("swchg_ui0", bus.user_input, 8'h41);
    bus.switches = 8'h7A;
    tick();
    chk8("swchg_ui1", bus.user_input, 8'h41);
    tick();
    chk8("swchg_ui2", bus.user_input, 8'h41);
    tick();
    chk8("swchg_ui3", bus.user_input, 8'h00);
    bus.submit_button = 1'b1;
    run_obs(15, 8'h7A, pulses, hits, bp_hi);
    chki("swchg_rel_hits", hits, 0);

    // Two presses separated by a 10-cycle release
    bus.switches = 8'h3C;
    repeat (2) tick();
    bus.submit_button = 1'b0;
    run_obs(12, 8'h3C, pulses, hits, bp_hi);
    chki("two_p1_pulses", pulses, 1);
    chki("two_p1_hits", hits, 3);
    bus.submit_button = 1'b1;
    bus.switches = 8'hC3;
    run_obs(10, 8'hC3, pulses, hits, bp_hi);
    chki("two_gap_pulses", pulses, 0);
    chki("two_gap_hits", hits, 0);
    bus.submit_button = 1'b0;
    run_obs(12, 8'hC3, pulses, hits, bp_hi);
    chki("two_p2_pulses", pulses, 1);
    chki("two_p2_hits", hits, 3);
    bus.submit_button = 1'b1;
    run_obs(15, 8'hC3, pulses, hits, bp_hi);

    // Reset on the second cycle of the window
    bus.switches = 8'h5A;
    repeat (2) tick();
    bus.submit_button = 1'b0;
    wait_pulse(found);
    chk1("midrst_found", found, 1'b1);
    tick();
    chk8("midrst_ui_pre", bus.user_input, 8'h5A);
    rst_n = 1'b0;
    bus.submit_button = 1'b1;
    #1;
    chk8("midrst_ui_async", bus.user_input, 8'h00);
    chk1("midrst_gv_async", bus.guess_valid, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    run_obs(12, 8'h5A, pulses, hits, bp_hi);
    chki("midrst_after_pulses", pulses, 0);
    chki("midrst_after_hits", hits, 0);
    chki("midrst_after_bp", bp_hi, 0);

    // Guess equal to IDLE_VALUE still pulses
    bus.switches = 8'h00;
    repeat (2) tick();
    bus.submit_button = 1'b0;
    run_obs(15, 8'h00, pulses, hits, bp_hi);
    chki("zero_pulses", pulses, 1);
    chk1("zero_bp", bus.button_pressed, 1'b1);
    bus.submit_button = 1'b1;
    run_obs(10, 8'h00, pulses, hits, bp_hi);
    chki("zero_rel_pulses", pulses, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
